// File: rtl/irq_pkg.sv
// Shared types and sizes for the interrupt pending controller slice.
package irq_pkg;

    localparam int unsigned N_IRQ = 8;
    localparam int unsigned IDX_W = $clog2(N_IRQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Valid/ready request channel from the pending controller to the dispatch stage.
interface irq_pending_ctrl_if;

    logic           irq_valid;
    irq_pkg::idx_t  irq_id;
    logic           irq_ready;

    modport master (
        output irq_valid,
        output irq_id,
        input  irq_ready
    );

    modport slave (
        input  irq_valid,
        input  irq_id,
        output irq_ready
    );

endinterface

// File: rtl/irq_prio_sel.sv
// Fixed-priority selector: lowest set index wins, plus an any-set flag.
module irq_prio_sel
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0] vec,
    output idx_t             idx_c,
    output logic             any_c
);

    // Scan from the top down so the lowest set bit is the last to overwrite.
    always_comb begin
        idx_c = '0;
        any_c = 1'b0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_c = IDX_W'(i);
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-detecting pending register with mask and a lowest-index-first valid/ready presenter.
// Optional build macro IRQ_OVF_EN adds per-source overflow flags (ovf) and their clear (ovf_clr).
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
`ifdef IRQ_OVF_EN
    input  logic               ovf_clr,
    output logic [N_IRQ-1:0]   ovf,
`endif
    input  logic [N_IRQ-1:0]   irq_in,
    input  logic               mask_wr,
    input  logic [N_IRQ-1:0]   mask_wdata,
    irq_pending_ctrl_if.master irq_bus,
    output logic [N_IRQ-1:0]   pending,
    output logic [N_IRQ-1:0]   mask
);

    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] irq_edge_c;
    logic [N_IRQ-1:0] clr_c;
    logic [N_IRQ-1:0] cand_c;
    logic [N_IRQ-1:0] pending_d;
    logic             accept_c;
    idx_t             sel_idx_c;
    logic             sel_any_c;

    state_t state_q;
    state_t state_d;
    logic   valid_q;
    logic   valid_d;
    idx_t   id_q;
    idx_t   id_d;

    assign irq_edge_c = irq_in & ~irq_q;
    assign accept_c   = valid_q & irq_bus.irq_ready;
    assign clr_c      = accept_c ? (N_IRQ'(1) << id_q) : '0;
    // A new edge on the bit being serviced re-arms it rather than being lost.
    assign pending_d  = (pending & ~clr_c) | irq_edge_c;
    assign cand_c     = pending & mask;

    irq_prio_sel u_prio_sel (
        .vec   (cand_c),
        .idx_c (sel_idx_c),
        .any_c (sel_any_c)
    );

    // Request capture and software mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_q   <= irq_in;
            pending <= pending_d;
            if (mask_wr) begin
                mask <= mask_wdata;
            end
        end
    end

    // Presenter next-state: a presented request is held until accepted, never retracted.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (sel_any_c) begin
                    state_d = PRESENT;
                    valid_d = 1'b1;
                    id_d    = sel_idx_c;
                end
            end
            PRESENT: begin
                if (accept_c) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign irq_bus.irq_valid = valid_q;
    assign irq_bus.irq_id    = id_q;

`ifdef IRQ_OVF_EN
    logic [N_IRQ-1:0] ovf_set_c;

    // Overflow: a fresh edge lands on a source that is still pending and not being serviced.
    assign ovf_set_c = irq_edge_c & pending & ~clr_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= ovf_set_c | (ovf & ~{N_IRQ{ovf_clr}});
        end
    end
`endif

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed vector bench for irq_pending_ctrl; overflow checks compile in with IRQ_OVF_EN.
module tb_irq_pending_ctrl;
    import irq_pkg::*;

    logic             clk;
    logic             rst;
    logic             mask_wr;
    logic [N_IRQ-1:0] irq_in;
    logic [N_IRQ-1:0] mask_wdata;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;
`ifdef IRQ_OVF_EN
    logic             ovf_clr;
    logic [N_IRQ-1:0] ovf;
`endif

    irq_pending_ctrl_if bus ();

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic             rst;
        logic [N_IRQ-1:0] irq;
        logic             mwr;
        logic [N_IRQ-1:0] mdat;
        logic             rdy;
        logic             ev;
        logic [IDX_W-1:0] eid;
        logic [N_IRQ-1:0] epend;
        logic [N_IRQ-1:0] emask;
    } vec_t;

    vec_t vt[$];

    irq_pending_ctrl dut (
        .clk        (clk),
        .rst        (rst),
`ifdef IRQ_OVF_EN
        .ovf_clr    (ovf_clr),
        .ovf        (ovf),
`endif
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .irq_bus    (bus),
        .pending    (pending),
        .mask       (mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic add(input logic r, input logic [7:0] irq, input logic mwr,
                       input logic [7:0] mdat, input logic rdy, input logic ev,
                       input int eid, input logic [7:0] ep, input logic [7:0] em);
        vec_t v;
        v.rst   = r;
        v.irq   = irq;
        v.mwr   = mwr;
        v.mdat  = mdat;
        v.rdy   = rdy;
        v.ev    = ev;
        v.eid   = IDX_W'(eid);
        v.epend = ep;
        v.emask = em;
        vt.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string nm, input logic ev, input logic [IDX_W-1:0] eid,
                               input logic [N_IRQ-1:0] ep, input logic [N_IRQ-1:0] em);
        n_vec++;
        if (bus.irq_valid !== ev || (ev && bus.irq_id !== eid) ||
            pending !== ep || mask !== em) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b id=%0d pending=%02h mask=%02h, want valid=%0b id=%0d pending=%02h mask=%02h",
                     nm, bus.irq_valid, bus.irq_id, pending, mask, ev, eid, ep, em);
        end
    endtask

`ifdef IRQ_OVF_EN
    task automatic check_ovf(input string nm, input logic [N_IRQ-1:0] eo);
        n_vec++;
        if (ovf !== eo) begin
            n_bad++;
            $display("FAIL %s: got ovf=%02h, want ovf=%02h", nm, ovf, eo);
        end
    endtask
`endif

    initial begin
        int w;
        rst           = 1'b1;
        irq_in        = '0;
        mask_wr       = 1'b0;
        mask_wdata    = '0;
        bus.irq_ready = 1'b0;
`ifdef IRQ_OVF_EN
        ovf_clr       = 1'b0;
`endif

        //  rst irq    mwr mdat   rdy ev id pend   mask
        add(1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);  // 0 reset
        add(0, 8'h00, 1, 8'hFF, 0, 0, 0, 8'h00, 8'hFF);  // 1 unmask all
        add(0, 8'h20, 0, 8'h00, 0, 0, 0, 8'h20, 8'hFF);  // 2 pulse src 5
        add(0, 8'h00, 0, 8'h00, 1, 1, 5, 8'h20, 8'hFF);  // 3 present 5, ready ignored
        add(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF);  // 4 accept
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);  // 5
        add(0, 8'h44, 0, 8'h00, 1, 0, 0, 8'h44, 8'hFF);  // 6 src 2 and 6 together
        add(0, 8'h44, 0, 8'h00, 1, 1, 2, 8'h44, 8'hFF);  // 7 id 2 first
        add(0, 8'h44, 0, 8'h00, 1, 0, 0, 8'h40, 8'hFF);  // 8 bubble
        add(0, 8'h44, 0, 8'h00, 1, 1, 6, 8'h40, 8'hFF);  // 9 id 6
        add(0, 8'h46, 0, 8'h00, 0, 1, 6, 8'h42, 8'hFF);  // 10 src 1 rises, no retraction
        add(0, 8'h46, 0, 8'h00, 0, 1, 6, 8'h42, 8'hFF);  // 11
        add(0, 8'h46, 0, 8'h00, 1, 0, 0, 8'h02, 8'hFF);  // 12 accept 6
        add(0, 8'h46, 0, 8'h00, 1, 1, 1, 8'h02, 8'hFF);  // 13 id 1
        add(0, 8'h46, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF);  // 14 accept 1
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);  // 15
        add(0, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 8'h00);  // 16 mask all off
        add(0, 8'h08, 0, 8'h00, 0, 0, 0, 8'h08, 8'h00);  // 17 masked edge still pends
        add(0, 8'h08, 0, 8'h00, 0, 0, 0, 8'h08, 8'h00);  // 18
        add(0, 8'h08, 1, 8'h08, 0, 0, 0, 8'h08, 8'h08);  // 19 mask write edge
        add(0, 8'h08, 0, 8'h00, 0, 1, 3, 8'h08, 8'h08);  // 20 valid one edge later
        add(0, 8'h08, 0, 8'h00, 1, 0, 0, 8'h00, 8'h08);  // 21 accept
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h08);  // 22
        add(0, 8'h00, 1, 8'hFF, 0, 0, 0, 8'h00, 8'hFF);  // 23
        add(0, 8'h10, 0, 8'h00, 0, 0, 0, 8'h10, 8'hFF);  // 24 src 4
        add(0, 8'h00, 0, 8'h00, 0, 1, 4, 8'h10, 8'hFF);  // 25
        add(0, 8'h10, 0, 8'h00, 1, 0, 0, 8'h10, 8'hFF);  // 26 accept + new edge: set wins
        add(0, 8'h10, 0, 8'h00, 0, 1, 4, 8'h10, 8'hFF);  // 27 re-presented after bubble
        add(0, 8'h10, 0, 8'h00, 1, 0, 0, 8'h00, 8'hFF);  // 28
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF);  // 29
        add(0, 8'h80, 0, 8'h00, 0, 0, 0, 8'h80, 8'hFF);  // 30 src 7
        add(0, 8'h80, 1, 8'h00, 0, 1, 7, 8'h80, 8'h00);  // 31 mask drops as it presents
        add(0, 8'h80, 0, 8'h00, 0, 1, 7, 8'h80, 8'h00);  // 32 still held
        add(0, 8'h80, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00);  // 33 accept
        add(0, 8'h80, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00);  // 34 ready while idle
        add(1, 8'h01, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);  // 35 reset with input high
        add(0, 8'h01, 0, 8'h00, 0, 0, 0, 8'h01, 8'h00);  // 36 seen as edge after release
        add(0, 8'h01, 1, 8'hFF, 0, 0, 0, 8'h01, 8'hFF);  // 37
        add(0, 8'h01, 0, 8'h00, 0, 1, 0, 8'h01, 8'hFF);  // 38 present 0
        add(1, 8'h01, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);  // 39 reset mid-handshake
        add(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);  // 40

        for (int i = 0; i < vt.size(); i++) begin
            rst           = vt[i].rst;
            irq_in        = vt[i].irq;
            mask_wr       = vt[i].mwr;
            mask_wdata    = vt[i].mdat;
            bus.irq_ready = vt[i].rdy;
            step();
            check_state($sformatf("vec%0d", i), vt[i].ev, vt[i].eid, vt[i].epend, vt[i].emask);
        end

        // All sources at once drain in index order, one bubble between grants.
        mask_wr    = 1'b1;
        mask_wdata = 8'hFF;
        step();
        mask_wr = 1'b0;
        irq_in  = 8'hFF;
        step();
        check_state("allrise", 1'b0, '0, 8'hFF, 8'hFF);
        irq_in        = 8'h00;
        bus.irq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = 0;
            while (!bus.irq_valid && w < 4) begin
                step();
                w++;
            end
            check_state($sformatf("drain_id%0d", k), 1'b1, IDX_W'(k), 8'(8'hFF << k), 8'hFF);
            n_vec++;
            if (w != 1) begin
                n_bad++;
                $display("FAIL drain_gap%0d: got %0d cycles to valid, want 1", k, w);
            end
            step();
        end
        check_state("drained", 1'b0, '0, 8'h00, 8'hFF);
        bus.irq_ready = 1'b0;

`ifdef IRQ_OVF_EN
        mask_wr    = 1'b1;
        mask_wdata = 8'h00;
        step();
        mask_wr = 1'b0;
        irq_in  = 8'h80;
        step();
        check_ovf("ovf_first", 8'h00);
        irq_in = 8'h00;
        step();
        irq_in = 8'h80;
        step();
        check_ovf("ovf_second", 8'h80);
        irq_in  = 8'h00;
        ovf_clr = 1'b1;
        step();
        check_ovf("ovf_clr", 8'h00);
        irq_in = 8'h80;
        step();
        check_ovf("ovf_set_wins", 8'h80);
        ovf_clr = 1'b0;
        rst     = 1'b1;
        step();
        check_ovf("ovf_reset", 8'h00);
        check_state("ovf_reset_state", 1'b0, '0, 8'h00, 8'h00);
        rst    = 1'b0;
        irq_in = 8'h00;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
